// File: rtl/vga_frame_decoder.sv
// vga_frame_decoder: receive-side monitor for a VGA stream.
// Recovers pixel coordinates from hsync/vsync timing, checks the line/frame
// timing, locks onto the frame and reports the top-left corner of the
// pixels that match the frog colour in the last completed frame.
// Ports:
//   clk, reset              pixel clock, asynchronous active-low reset
//   red/green/blue          3-bit colour components from the controller
//   hsync, vsync            sync inputs (SYNC_ACTIVE level = asserted)
//   locked                  timing locked
//   pixel_valid/x/y         registered sample is visible, and its coordinate
//   frog_found/x/y          frog result of the last completed frame
//   frame_done              one-cycle pulse per completed locked frame
//   err_count               saturating count of timing errors seen while locked
// Next-state logic works on the pins, so every output register is aligned
// with the sample held in the input register (one cycle from the pins).
module vga_frame_decoder #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter logic        SYNC_ACTIVE = 1'b0,
  parameter logic [8:0]  FROG_RGB    = 9'b000_111_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] red,
  input  logic [2:0] green,
  input  logic [2:0] blue,
  input  logic       hsync,
  input  logic       vsync,
  output logic       locked,
  output logic       pixel_valid,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frog_found,
  output logic [9:0] frog_x,
  output logic [9:0] frog_y,
  output logic       frame_done,
  output logic [7:0] err_count
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_C = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_C = CW'(V_SYNC);
  localparam logic [CW-1:0] H_START  = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_END    = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_START  = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_END    = CW'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          flag_q, flag_d;
  logic          hs_q, vs_q;
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic          locked_q;
  logic          pixel_valid_q, pixel_valid_d;
  logic [CW-1:0] pixel_x_q, pixel_x_d;
  logic [CW-1:0] pixel_y_q, pixel_y_d;
  logic [CW-1:0] min_x_q, min_x_d;
  logic [CW-1:0] min_y_q, min_y_d;
  logic          seen_q, seen_d;
  logic          frog_found_q, frog_found_d;
  logic [CW-1:0] frog_x_q, frog_x_d;
  logic [CW-1:0] frog_y_q, frog_y_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    err_count_q, err_count_d;

  logic          hs_n, vs_n, hs_rise, vs_rise;
  logic          h_err, v_err, err;
  logic          window;
  logic [CW-1:0] cur_x, cur_y;
  logic          rgb_match;

  // Sync decode; edges compare the incoming sample against the registered one.
  assign hs_n    = (hsync == SYNC_ACTIVE);
  assign vs_n    = (vsync == SYNC_ACTIVE);
  assign hs_rise = hs_n & ~hs_q;
  assign vs_rise = vs_n & ~vs_q;

  // Counters and timing checks for the incoming sample.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    h_err   = 1'b0;
    v_err   = 1'b0;

    if (hs_rise) begin
      h_cnt_d = '0;
    end else if (h_cnt_q != CNT_MAX) begin
      h_cnt_d = h_cnt_q + CW'(1);
    end

    // vsync edge wins when both edges land on the same sample
    if (vs_rise) begin
      v_cnt_d = '0;
    end else if (hs_rise && (v_cnt_q != CNT_MAX)) begin
      v_cnt_d = v_cnt_q + CW'(1);
    end

    if (hs_rise) begin
      h_err = (h_cnt_q != H_LAST);
    end else begin
      h_err = (hs_n != (h_cnt_d < H_SYNC_C));
    end

    if (vs_rise && (v_cnt_q != V_LAST)) begin
      v_err = 1'b1;
    end
    if (hs_rise && (vs_n != (v_cnt_d < V_SYNC_C))) begin
      v_err = 1'b1;
    end

    err = (state_q != SEARCH) && (h_err || v_err);
  end

  // Lock FSM: one clean frame in ALIGN is required before LOCKED.
  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    case (state_q)
      SEARCH: begin
        if (vs_rise) begin
          state_d = ALIGN;
          flag_d  = 1'b0;
        end
      end
      ALIGN: begin
        if (vs_rise) begin
          if (!flag_q && !err) begin
            state_d = LOCKED;
          end
          flag_d = 1'b0;
        end else if (err) begin
          flag_d = 1'b1;
        end
      end
      LOCKED: begin
        if (err) begin
          state_d = SEARCH;
        end
      end
      default: begin
        state_d = SEARCH;
        flag_d  = 1'b0;
      end
    endcase
  end

  // Visible window, coordinates and frog tracking.
  always_comb begin
    window    = (h_cnt_d >= H_START) && (h_cnt_d < H_END) &&
                (v_cnt_d >= V_START) && (v_cnt_d < V_END);
    cur_x     = h_cnt_d - H_START;
    cur_y     = v_cnt_d - V_START;
    rgb_match = ({red, green, blue} == FROG_RGB);

    pixel_valid_d = window && (state_d == LOCKED);
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    min_x_d       = min_x_q;
    min_y_d       = min_y_q;
    seen_d        = seen_q;
    frog_found_d  = frog_found_q;
    frog_x_d      = frog_x_q;
    frog_y_d      = frog_y_q;
    frame_done_d  = 1'b0;
    err_count_d   = err_count_q;

    if (pixel_valid_d) begin
      pixel_x_d = cur_x;
      pixel_y_d = cur_y;
    end

    if (vs_rise) begin
      min_x_d = CNT_MAX;
      min_y_d = CNT_MAX;
      seen_d  = 1'b0;
    end else if (pixel_valid_d && rgb_match) begin
      if (cur_x < min_x_q) min_x_d = cur_x;
      if (cur_y < min_y_q) min_y_d = cur_y;
      seen_d = 1'b1;
    end

    // Publish the frame that just ended; seen_q already covers its last pixel.
    if (vs_rise && (state_q == LOCKED) && !err) begin
      frog_found_d = seen_q;
      frame_done_d = 1'b1;
      if (seen_q) begin
        frog_x_d = min_x_q;
        frog_y_d = min_y_q;
      end
    end

    if ((state_q == LOCKED) && (state_d != LOCKED)) begin
      frog_found_d = 1'b0;
    end

    if ((state_q == LOCKED) && err && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= SEARCH;
      flag_q        <= 1'b0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      locked_q      <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      min_x_q       <= '0;
      min_y_q       <= '0;
      seen_q        <= 1'b0;
      frog_found_q  <= 1'b0;
      frog_x_q      <= '0;
      frog_y_q      <= '0;
      frame_done_q  <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      flag_q        <= flag_d;
      hs_q          <= hs_n;
      vs_q          <= vs_n;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      locked_q      <= (state_d == LOCKED);
      pixel_valid_q <= pixel_valid_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      min_x_q       <= min_x_d;
      min_y_q       <= min_y_d;
      seen_q        <= seen_d;
      frog_found_q  <= frog_found_d;
      frog_x_q      <= frog_x_d;
      frog_y_q      <= frog_y_d;
      frame_done_q  <= frame_done_d;
      err_count_q   <= err_count_d;
    end
  end

  assign locked      = locked_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign frog_found  = frog_found_q;
  assign frog_x      = frog_x_q;
  assign frog_y      = frog_y_q;
  assign frame_done  = frame_done_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_vga_frame_decoder.sv
// tb_vga_frame_decoder: directed frames for vga_frame_decoder using a
// shrunken timing (25 clocks x 19 lines) so a frame is only 475 cycles.
module tb_vga_frame_decoder;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int XO = HS + HB;
  localparam int YO = VS + VB;
  localparam logic [8:0] FROG = 9'b000_111_000;

  logic       clk, reset;
  logic [2:0] red, green, blue;
  logic       hsync, vsync;
  logic       locked, pixel_valid, frog_found, frame_done;
  logic [9:0] pixel_x, pixel_y, frog_x, frog_y;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Outputs right after the first (vsync-edge) sample of a frame.
  int e_locked, e_fd, e_ff, e_fx, e_fy, e_err;
  // Outputs after the last sample of a frame, and per-frame counters.
  int z_locked, z_ff, z_fx, z_err, z_px, z_py;
  int fd_count, corner_count;

  vga_frame_decoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE(1'b0), .FROG_RGB(FROG)
  ) dut (
    .clk(clk), .reset(reset),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync),
    .locked(locked), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frog_found(frog_found), .frog_x(frog_x), .frog_y(frog_y),
    .frame_done(frame_done), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({locked, pixel_valid, pixel_x, pixel_y, frog_found,
                frog_x, frog_y, frame_done, err_count});
  endfunction

  // One frame from its vsync edge; frog block (fx,fy,fw,fh) in visible
  // coordinates, optional frog colour in blanking only, optional line one
  // clock short, optional early stop after max_samples samples.
  task automatic drive_frame(input int fx, input int fy, input int fw, input int fh,
                             input bit blank_frog, input int short_line,
                             input int max_samples);
    int samples = 0;
    fd_count     = 0;
    corner_count = 0;
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < ((v == short_line) ? HT - 1 : HT); h++) begin
        bit vis;
        logic [8:0] rgb;
        int x, y;
        if (max_samples >= 0 && samples == max_samples) return;
        vis   = (h >= XO) && (h < XO + HA) && (v >= YO) && (v < YO + VA);
        x     = h - XO;
        y     = v - YO;
        rgb   = 9'd0;
        if (vis && x >= fx && x < fx + fw && y >= fy && y < fy + fh) rgb = FROG;
        if (!vis && blank_frog) rgb = FROG;
        hsync = (h < HS) ? 1'b0 : 1'b1;
        vsync = (v < VS) ? 1'b0 : 1'b1;
        {red, green, blue} = rgb;
        @(posedge clk);
        #1;
        if (samples == 0) begin
          e_locked = int'(locked);
          e_fd     = int'(frame_done);
          e_ff     = int'(frog_found);
          e_fx     = int'(frog_x);
          e_fy     = int'(frog_y);
          e_err    = int'(err_count);
        end
        if (frame_done) fd_count++;
        if (pixel_valid && pixel_x == 10'(HA - 1) && pixel_y == 10'(VA - 1)) corner_count++;
        samples++;
      end
    end
    z_locked = int'(locked);
    z_ff     = int'(frog_found);
    z_fx     = int'(frog_x);
    z_err    = int'(err_count);
    z_px     = int'(pixel_x);
    z_py     = int'(pixel_y);
  endtask

  initial begin
    bit rst_bad;
    reset = 1'b0;
    hsync = 1'b1; vsync = 1'b1;
    red = '0; green = '0; blue = '0;

    // Inputs toggle under reset; outputs must stay zero.
    rst_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      {red, green, blue} = 9'($urandom);
      hsync = 1'($urandom);
      vsync = 1'($urandom);
      @(posedge clk);
      #1;
      if (all_outs() != 64'd0) rst_bad = 1'b1;
    end
    check("rst_outs_zero", 64'(rst_bad), 64'd0);
    check("rst_outs_final", all_outs(), 64'd0);
    reset = 1'b1;

    // Cold start: lock at the second vsync edge, report at the third.
    drive_frame(8, 6, 4, 4, 1'b0, -1, -1);
    check("e1_locked", 64'(e_locked), 64'd0);
    drive_frame(8, 6, 4, 4, 1'b0, -1, -1);
    check("e2_locked", 64'(e_locked), 64'd1);
    check("e2_frame_done", 64'(e_fd), 64'd0);
    drive_frame(0, 0, 0, 0, 1'b0, -1, -1);
    check("e3_frame_done", 64'(e_fd), 64'd1);
    check("e3_frog_found", 64'(e_ff), 64'd1);
    check("e3_frog_x", 64'(e_fx), 64'd8);
    check("e3_frog_y", 64'(e_fy), 64'd6);
    check("f3_corner_once", 64'(corner_count), 64'd1);
    check("f3_one_done", 64'(fd_count), 64'd1);
    check("f3_px_hold", 64'(z_px), 64'(HA - 1));
    check("f3_py_hold", 64'(z_py), 64'(VA - 1));

    // Empty frame: found drops, position holds. Then frog colour in blanking only.
    drive_frame(0, 0, 0, 0, 1'b1, -1, -1);
    check("e4_frame_done", 64'(e_fd), 64'd1);
    check("e4_frog_found", 64'(e_ff), 64'd0);
    check("e4_frog_x_hold", 64'(e_fx), 64'd8);
    check("e4_frog_y_hold", 64'(e_fy), 64'd6);

    // Corner pixels in separate frames.
    drive_frame(0, 0, 1, 1, 1'b0, -1, -1);
    check("e5_blank_frog", 64'(e_ff), 64'd0);
    check("e5_frame_done", 64'(e_fd), 64'd1);
    drive_frame(HA - 1, VA - 1, 1, 1, 1'b0, -1, -1);
    check("e6_frog_found", 64'(e_ff), 64'd1);
    check("e6_frog_x", 64'(e_fx), 64'd0);
    check("e6_frog_y", 64'(e_fy), 64'd0);
    check("f6_corner_once", 64'(corner_count), 64'd1);

    // Short line while locked.
    drive_frame(0, 0, 0, 0, 1'b0, 3, -1);
    check("e7_frog_x", 64'(e_fx), 64'(HA - 1));
    check("e7_frog_y", 64'(e_fy), 64'(VA - 1));
    check("f7_locked_after_err", 64'(z_locked), 64'd0);
    check("f7_err_count", 64'(z_err), 64'd1);
    check("f7_found_cleared", 64'(z_ff), 64'd0);
    check("f7_frog_x_hold", 64'(z_fx), 64'(HA - 1));
    drive_frame(0, 0, 0, 0, 1'b0, -1, -1);
    check("e8_align_locked", 64'(e_locked), 64'd0);
    check("e8_frame_done", 64'(e_fd), 64'd0);
    drive_frame(0, 0, 0, 0, 1'b0, -1, 10 * HT + 10);
    check("e9_relocked", 64'(e_locked), 64'd1);
    check("e9_err_count", 64'(e_err), 64'd1);

    // Asynchronous reset mid-line while locked.
    #2 reset = 1'b0;
    #1 check("async_rst_outs", all_outs(), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    drive_frame(0, 0, 0, 0, 1'b0, -1, -1);
    check("e10_locked", 64'(e_locked), 64'd0);
    drive_frame(0, 0, 0, 0, 1'b0, -1, -1);
    check("e11_locked", 64'(e_locked), 64'd1);
    check("e11_err_count", 64'(e_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
